// File: rtl/chess_pkg.sv
// Shared encoding for the systolic move-generator array: piece codes, ray and
// knight message fields, and the direction numbering used by every cell.
package chess_pkg;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  localparam logic [5:0] EMPTY_PIECE  = 6'b000000;
  localparam logic [4:0] PIECE_ROOK   = 5'b10000;
  localparam logic [4:0] PIECE_BISHOP = 5'b01000;
  localparam logic [4:0] PIECE_QUEEN  = 5'b11000;
  localparam logic [4:0] PIECE_KING   = 5'b00100;
  localparam logic [4:0] PIECE_PAWN   = 5'b00010;
  localparam logic [4:0] PIECE_KNIGHT = 5'b00001;

  localparam logic [3:0] ATK_NONE   = 4'b0000;
  localparam logic [3:0] ATK_ROOK   = 4'b1000;
  localparam logic [3:0] ATK_BISHOP = 4'b0100;
  localparam logic [3:0] ATK_QUEEN  = 4'b1100;
  localparam logic [3:0] ATK_KING   = 4'b0010;
  localparam logic [3:0] ATK_PAWN   = 4'b0001;

  localparam logic [10:0] EMPTY_MOVE        = 11'b0;
  localparam logic [7:0]  EMPTY_KNIGHT_MOVE = 8'b0;

  localparam int PIECE_COLOR = 5;
  localparam int RAY_COLOR   = 10;
  localparam int RAY_ATK_HI  = 9;
  localparam int RAY_ATK_LO  = 6;
  localparam int RAY_POS_HI  = 5;
  localparam int KN_COLOR    = 7;
  localparam int KN_VALID    = 6;

  // Opposite ray directions differ only in bit 0, so X' = X ^ 1.
  typedef enum logic [2:0] {
    DIR_U, DIR_D, DIR_L, DIR_R, DIR_UL, DIR_DR, DIR_UR, DIR_DL
  } ray_dir_e;

  typedef enum logic [2:0] {
    KN_UUL, KN_UUR, KN_LLU, KN_RRU, KN_DDL, KN_DDR, KN_LLD, KN_RRD
  } knight_dir_e;

endpackage

// File: rtl/ray_dir_cell.sv
// One ray direction of a board square: next outgoing ray toward the neighbour
// and the move word for a ray landing here from that neighbour.
module ray_dir_cell
  import chess_pkg::*;
#(
  parameter bit ORTHO = 1'b1
) (
  input  logic        engine_color,
  input  logic        is_empty,
  input  logic        is_own,
  input  logic        is_enemy,
  input  logic        piece_color,
  input  logic [5:0]  pos,
  input  logic [3:0]  orig_attack,
  input  logic [10:0] pass_in,
  input  logic [10:0] land_in,
  output logic [10:0] ray_out,
  output logic [10:0] move
);

  localparam int SLIDE_IDX = ORTHO ? 3 : 2;

  logic [3:0] pass_attack;
  logic [3:0] land_attack;
  logic       land_valid;
  logic       pawn_only;

  assign pass_attack = pass_in[RAY_ATK_HI:RAY_ATK_LO];
  assign land_attack = land_in[RAY_ATK_HI:RAY_ATK_LO];
  assign land_valid  = (land_attack != ATK_NONE) && (land_in[RAY_COLOR] == engine_color);
  assign pawn_only   = (land_attack == ATK_PAWN);

  // Slider bits travel on; king and pawn attacks reach one square only.
  always_comb begin
    ray_out = EMPTY_MOVE;
    if (is_empty) begin
      if (pass_in[RAY_COLOR] == engine_color && pass_attack[SLIDE_IDX])
        ray_out = {pass_in[RAY_COLOR], pass_attack & ATK_QUEEN, pass_in[RAY_POS_HI:0]};
    end else if (is_own) begin
      if (orig_attack != ATK_NONE)
        ray_out = {piece_color, orig_attack, pos};
    end
  end

  // Pawns push onto empty squares straight ahead and capture diagonally.
  always_comb begin
    move = EMPTY_MOVE;
    if (land_valid) begin
      if (is_empty && (!pawn_only || ORTHO))
        move = land_in;
      else if (is_enemy && (!pawn_only || !ORTHO))
        move = land_in;
    end
  end

endmodule

// File: rtl/board_square.sv
// One square of the 8x8 move-generator array: forwards sliding rays, originates
// rays and knight tokens for engine pieces, and reports legal landings here.
module board_square
  import chess_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        engineColor,
  input  logic [5:0]  pieceReg,
  input  logic        enable,
  input  logic        clear,
  input  logic [5:0]  posReg,
  input  logic [10:0] U_in,  D_in,  L_in,  R_in,
  input  logic [10:0] UL_in, UR_in, DL_in, DR_in,
  input  logic [7:0]  UUL_in, UUR_in, LLU_in, RRU_in,
  input  logic [7:0]  DDL_in, DDR_in, LLD_in, RRD_in,
  output logic [10:0] U_out,  D_out,  L_out,  R_out,
  output logic [10:0] UL_out, UR_out, DL_out, DR_out,
  output logic [7:0]  UUL_out, UUR_out, LLU_out, RRU_out,
  output logic [7:0]  DDL_out, DDR_out, LLD_out, RRD_out,
  output logic [10:0] U_move,  D_move,  L_move,  R_move,
  output logic [10:0] UL_move, UR_move, DL_move, DR_move,
  output logic [7:0]  UUL_move, UUR_move, LLU_move, RRU_move,
  output logic [7:0]  DDL_move, DDR_move, LLD_move, RRD_move
);

  logic [10:0] ray_in   [8];
  logic [7:0]  kn_in    [8];
  logic [10:0] ray_nxt  [8];
  logic [10:0] move_nxt [8];
  logic [7:0]  kn_nxt   [8];
  logic [7:0]  knm_nxt  [8];
  logic [3:0]  orig_atk [8];
  logic [10:0] ray_q    [8];
  logic [10:0] move_q   [8];
  logic [7:0]  kn_q     [8];
  logic [7:0]  knm_q    [8];

  assign ray_in[DIR_U]  = U_in;   assign ray_in[DIR_D]  = D_in;
  assign ray_in[DIR_L]  = L_in;   assign ray_in[DIR_R]  = R_in;
  assign ray_in[DIR_UL] = UL_in;  assign ray_in[DIR_DR] = DR_in;
  assign ray_in[DIR_UR] = UR_in;  assign ray_in[DIR_DL] = DL_in;
  assign kn_in[KN_UUL] = UUL_in;  assign kn_in[KN_UUR] = UUR_in;
  assign kn_in[KN_LLU] = LLU_in;  assign kn_in[KN_RRU] = RRU_in;
  assign kn_in[KN_DDL] = DDL_in;  assign kn_in[KN_DDR] = DDR_in;
  assign kn_in[KN_LLD] = LLD_in;  assign kn_in[KN_RRD] = RRD_in;

  logic is_empty, is_own, is_enemy, is_white;
  logic slide_ortho, slide_diag, is_king, is_pawn, is_knight;

  assign is_empty    = (pieceReg[4:0] == EMPTY_PIECE[4:0]);
  assign is_own      = !is_empty && (pieceReg[PIECE_COLOR] == engineColor);
  assign is_enemy    = !is_empty && !is_own;
  assign is_white    = (pieceReg[PIECE_COLOR] == WHITE);
  assign slide_ortho = (pieceReg[4:0] == PIECE_ROOK)   || (pieceReg[4:0] == PIECE_QUEEN);
  assign slide_diag  = (pieceReg[4:0] == PIECE_BISHOP) || (pieceReg[4:0] == PIECE_QUEEN);
  assign is_king     = (pieceReg[4:0] == PIECE_KING);
  assign is_pawn     = (pieceReg[4:0] == PIECE_PAWN);
  assign is_knight   = (pieceReg[4:0] == PIECE_KNIGHT);

  // Pawn attacks only point forward: up the board for white, down for black.
  always_comb begin
    for (int d = 0; d < 8; d++) begin
      orig_atk[d] = is_king ? ATK_KING : ATK_NONE;
      if (d < 4 && slide_ortho)  orig_atk[d] = orig_atk[d] | ATK_ROOK;
      if (d >= 4 && slide_diag)  orig_atk[d] = orig_atk[d] | ATK_BISHOP;
    end
    orig_atk[DIR_U]  = orig_atk[DIR_U]  | {3'b0, is_pawn &&  is_white};
    orig_atk[DIR_UL] = orig_atk[DIR_UL] | {3'b0, is_pawn &&  is_white};
    orig_atk[DIR_UR] = orig_atk[DIR_UR] | {3'b0, is_pawn &&  is_white};
    orig_atk[DIR_D]  = orig_atk[DIR_D]  | {3'b0, is_pawn && !is_white};
    orig_atk[DIR_DL] = orig_atk[DIR_DL] | {3'b0, is_pawn && !is_white};
    orig_atk[DIR_DR] = orig_atk[DIR_DR] | {3'b0, is_pawn && !is_white};
  end

  for (genvar i = 0; i < 8; i++) begin : g_ray
    ray_dir_cell #(.ORTHO(i < 4)) u_cell (
      .engine_color (engineColor),
      .is_empty     (is_empty),
      .is_own       (is_own),
      .is_enemy     (is_enemy),
      .piece_color  (pieceReg[PIECE_COLOR]),
      .pos          (posReg),
      .orig_attack  (orig_atk[i]),
      .pass_in      (ray_in[i ^ 1]),
      .land_in      (ray_in[i]),
      .ray_out      (ray_nxt[i]),
      .move         (move_nxt[i])
    );
  end

  // Knight tokens are one hop only and never pass through a square.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      kn_nxt[k]  = (is_own && is_knight) ? {pieceReg[PIECE_COLOR], 1'b1, posReg} : EMPTY_KNIGHT_MOVE;
      knm_nxt[k] = (kn_in[k][KN_VALID] && kn_in[k][KN_COLOR] == engineColor && !is_own)
                   ? kn_in[k] : EMPTY_KNIGHT_MOVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        ray_q[i] <= EMPTY_MOVE;        move_q[i] <= EMPTY_MOVE;
        kn_q[i]  <= EMPTY_KNIGHT_MOVE; knm_q[i]  <= EMPTY_KNIGHT_MOVE;
      end
    end else if (clear) begin
      for (int i = 0; i < 8; i++) begin
        ray_q[i] <= EMPTY_MOVE;        move_q[i] <= EMPTY_MOVE;
        kn_q[i]  <= EMPTY_KNIGHT_MOVE; knm_q[i]  <= EMPTY_KNIGHT_MOVE;
      end
    end else if (enable) begin
      for (int i = 0; i < 8; i++) begin
        ray_q[i] <= ray_nxt[i]; move_q[i] <= move_nxt[i];
        kn_q[i]  <= kn_nxt[i];  knm_q[i]  <= knm_nxt[i];
      end
    end
  end

  assign U_out  = ray_q[DIR_U];   assign D_out  = ray_q[DIR_D];
  assign L_out  = ray_q[DIR_L];   assign R_out  = ray_q[DIR_R];
  assign UL_out = ray_q[DIR_UL];  assign DR_out = ray_q[DIR_DR];
  assign UR_out = ray_q[DIR_UR];  assign DL_out = ray_q[DIR_DL];
  assign U_move  = move_q[DIR_U];  assign D_move  = move_q[DIR_D];
  assign L_move  = move_q[DIR_L];  assign R_move  = move_q[DIR_R];
  assign UL_move = move_q[DIR_UL]; assign DR_move = move_q[DIR_DR];
  assign UR_move = move_q[DIR_UR]; assign DL_move = move_q[DIR_DL];
  assign UUL_out = kn_q[KN_UUL];  assign UUR_out = kn_q[KN_UUR];
  assign LLU_out = kn_q[KN_LLU];  assign RRU_out = kn_q[KN_RRU];
  assign DDL_out = kn_q[KN_DDL];  assign DDR_out = kn_q[KN_DDR];
  assign LLD_out = kn_q[KN_LLD];  assign RRD_out = kn_q[KN_RRD];
  assign UUL_move = knm_q[KN_UUL]; assign UUR_move = knm_q[KN_UUR];
  assign LLU_move = knm_q[KN_LLU]; assign RRU_move = knm_q[KN_RRU];
  assign DDL_move = knm_q[KN_DDL]; assign DDR_move = knm_q[KN_DDR];
  assign LLD_move = knm_q[KN_LLD]; assign RRD_move = knm_q[KN_RRD];

endmodule

// File: tb/tb_board_square.sv
// Bench for one board square: directed scenarios then random boards and
// messages, compared against a rule-level model of the square.
module tb_board_square;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, engine_color, enable, clear;
  logic [5:0]  piece_reg, pos_reg;
  // Direction order: 0 U, 1 D, 2 L, 3 R, 4 UL, 5 DR, 6 UR, 7 DL
  logic [10:0] ray_in [8];
  logic [10:0] ray_out [8];
  logic [10:0] ray_move [8];
  // Knight order: 0 UUL, 1 UUR, 2 LLU, 3 RRU, 4 DDL, 5 DDR, 6 LLD, 7 RRD
  logic [7:0]  kn_in [8];
  logic [7:0]  kn_out [8];
  logic [7:0]  kn_move [8];

  logic [10:0] exp_ray_out [8];
  logic [10:0] exp_ray_move [8];
  logic [7:0]  exp_kn_out [8];
  logic [7:0]  exp_kn_move [8];

  int compared = 0;
  int mismatched = 0;

  int opp_tbl [8] = '{1, 0, 3, 2, 5, 4, 7, 6};
  int atk_tbl [7] = '{0, 8, 4, 12, 2, 1, 3};
  logic [5:0] piece_tbl [14] = '{6'b000000, 6'b100000, 6'b010000, 6'b110000,
                                6'b001000, 6'b101000, 6'b011000, 6'b111000,
                                6'b000100, 6'b100100, 6'b000010, 6'b100010,
                                6'b000001, 6'b100001};

  board_square dut (
    .clk(clk), .rst_n(rst_n), .engineColor(engine_color), .pieceReg(piece_reg),
    .enable(enable), .clear(clear), .posReg(pos_reg),
    .U_in(ray_in[0]), .D_in(ray_in[1]), .L_in(ray_in[2]), .R_in(ray_in[3]),
    .UL_in(ray_in[4]), .DR_in(ray_in[5]), .UR_in(ray_in[6]), .DL_in(ray_in[7]),
    .UUL_in(kn_in[0]), .UUR_in(kn_in[1]), .LLU_in(kn_in[2]), .RRU_in(kn_in[3]),
    .DDL_in(kn_in[4]), .DDR_in(kn_in[5]), .LLD_in(kn_in[6]), .RRD_in(kn_in[7]),
    .U_out(ray_out[0]), .D_out(ray_out[1]), .L_out(ray_out[2]), .R_out(ray_out[3]),
    .UL_out(ray_out[4]), .DR_out(ray_out[5]), .UR_out(ray_out[6]), .DL_out(ray_out[7]),
    .UUL_out(kn_out[0]), .UUR_out(kn_out[1]), .LLU_out(kn_out[2]), .RRU_out(kn_out[3]),
    .DDL_out(kn_out[4]), .DDR_out(kn_out[5]), .LLD_out(kn_out[6]), .RRD_out(kn_out[7]),
    .U_move(ray_move[0]), .D_move(ray_move[1]), .L_move(ray_move[2]), .R_move(ray_move[3]),
    .UL_move(ray_move[4]), .DR_move(ray_move[5]), .UR_move(ray_move[6]), .DL_move(ray_move[7]),
    .UUL_move(kn_move[0]), .UUR_move(kn_move[1]), .LLU_move(kn_move[2]), .RRU_move(kn_move[3]),
    .DDL_move(kn_move[4]), .DDR_move(kn_move[5]), .LLD_move(kn_move[6]), .RRD_move(kn_move[7])
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] piece_attack(int d);
    int kind = int'(piece_reg[4:0]);
    bit white = piece_reg[5];
    bit fwd = white ? (d == 0 || d == 4 || d == 6) : (d == 1 || d == 5 || d == 7);
    int a = 0;
    if ((kind == 16 || kind == 24) && d < 4) a += 8;
    if ((kind == 8 || kind == 24) && d >= 4) a += 4;
    if (kind == 4) a += 2;
    if (kind == 2 && fwd) a += 1;
    return a[3:0];
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 8; i++) begin
      exp_ray_out[i] = '0; exp_ray_move[i] = '0;
      exp_kn_out[i] = '0;  exp_kn_move[i] = '0;
    end
  endtask

  task automatic model_clock();
    bit empty_sq, own_sq;
    logic [10:0] m;
    logic [3:0]  a, need;
    if (clear) begin
      model_zero();
      return;
    end
    if (!enable) return;
    empty_sq = (piece_reg[4:0] == 5'd0);
    own_sq = !empty_sq && (piece_reg[5] == engine_color);
    for (int d = 0; d < 8; d++) begin
      exp_ray_out[d] = '0;
      if (empty_sq) begin
        m = ray_in[opp_tbl[d]];
        need = (d < 4) ? 4'b1000 : 4'b0100;
        if (m[10] == engine_color && (m[9:6] & need) != 4'b0)
          exp_ray_out[d] = {m[10], m[9:6] & 4'b1100, m[5:0]};
      end else if (own_sq) begin
        a = piece_attack(d);
        if (a != 4'b0) exp_ray_out[d] = {piece_reg[5], a, pos_reg};
      end
      m = ray_in[d];
      exp_ray_move[d] = '0;
      if (m[9:6] != 4'b0 && m[10] == engine_color && !own_sq) begin
        if (empty_sq && !(m[9:6] == 4'b0001 && d >= 4)) exp_ray_move[d] = m;
        if (!empty_sq && !(m[9:6] == 4'b0001 && d < 4)) exp_ray_move[d] = m;
      end
    end
    for (int k = 0; k < 8; k++) begin
      exp_kn_out[k] = (own_sq && piece_reg[4:0] == 5'b00001) ? {piece_reg[5], 1'b1, pos_reg} : 8'h00;
      exp_kn_move[k] = (kn_in[k][6] && kn_in[k][7] == engine_color && !own_sq) ? kn_in[k] : 8'h00;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s ray_out[%0d]", tag, i), ray_out[i], exp_ray_out[i]);
      chk($sformatf("%s ray_move[%0d]", tag, i), ray_move[i], exp_ray_move[i]);
      chk($sformatf("%s kn_out[%0d]", tag, i), {3'b0, kn_out[i]}, {3'b0, exp_kn_out[i]});
      chk($sformatf("%s kn_move[%0d]", tag, i), {3'b0, kn_move[i]}, {3'b0, exp_kn_move[i]});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_msgs();
    for (int i = 0; i < 8; i++) begin
      ray_in[i] = '0;
      kn_in[i] = '0;
    end
  endtask

  task automatic step(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_zero();
    #1 check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [10:0] rand_ray();
    logic [3:0] atk;
    logic col;
    int idx = $urandom_range(0, 7);
    atk = (idx == 7) ? 4'($urandom_range(0, 15)) : 4'(atk_tbl[idx]);
    col = ($urandom_range(0, 3) != 0) ? engine_color : ~engine_color;
    return {col, atk, 6'($urandom_range(0, 63))};
  endfunction

  initial begin
    rst_n = 1'b0; engine_color = 1'b0; enable = 1'b0; clear = 1'b0;
    piece_reg = '0; pos_reg = '0;
    clear_msgs();
    model_zero();
    repeat (2) @(posedge clk);
    #1 check_all("reset");

    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; pos_reg = 6'd28;
    ray_in[1] = {1'b0, 4'b1000, 6'd20};
    step("rook_pass");
    chk("rook_pass U_out", ray_out[0], 11'b0_1000_010100);
    chk("rook_pass D_move", ray_move[1], 11'b0_1000_010100);
    chk("rook_pass D_out", ray_out[1], 11'b0);

    @(negedge clk);
    clear_msgs();
    ray_in[2] = {1'b0, 4'b1100, 6'd29};
    step("queen_pass");
    chk("queen_pass R_out", ray_out[3], 11'b0_1100_011101);
    chk("queen_pass L_move", ray_move[2], 11'b0_1100_011101);

    @(negedge clk);
    clear_msgs();
    ray_in[7] = {1'b0, 4'b0100, 6'd19};
    kn_in[1] = {1'b0, 1'b1, 6'd43};
    step("bishop_knight");
    chk("bishop UR_out", ray_out[6], 11'b0_0100_010011);
    chk("bishop DL_move", ray_move[7], 11'b0_0100_010011);
    chk("knight UUR_move", {3'b0, kn_move[1]}, 11'b000_0_1_101011);

    @(negedge clk);
    piece_reg = 6'b0_10000;
    ray_in[1] = {1'b0, 4'b1000, 6'd20};
    ray_in[2] = {1'b0, 4'b1100, 6'd29};
    step("own_rook");
    chk("own_rook U_out", ray_out[0], 11'b0_1000_011100);
    chk("own_rook L_out", ray_out[2], 11'b0_1000_011100);
    chk("own_rook UR_out", ray_out[6], 11'b0);

    @(negedge clk);
    clear_msgs();
    piece_reg = 6'b1_00010;
    ray_in[1] = {1'b0, 4'b1000, 6'd20};
    step("enemy_capture");
    chk("enemy D_move", ray_move[1], 11'b0_1000_010100);
    chk("enemy U_out", ray_out[0], 11'b0);

    @(negedge clk);
    ray_in[1] = {1'b0, 4'b0001, 6'd20};
    ray_in[7] = {1'b0, 4'b0001, 6'd19};
    step("pawn_capture");
    chk("pawn straight D_move", ray_move[1], 11'b0);
    chk("pawn diag DL_move", ray_move[7], 11'b0_0001_010011);

    @(negedge clk);
    enable = 1'b0;
    piece_reg = 6'b0;
    for (int i = 0; i < 8; i++) ray_in[i] = rand_ray();
    step("hold");
    chk("hold DL_move", ray_move[7], 11'b0_0001_010011);

    @(negedge clk);
    enable = 1'b1; clear = 1'b1;
    step("clear");
    clear = 1'b0;

    @(negedge clk);
    clear_msgs();
    piece_reg = 6'b0_11000;
    step("own_queen");
    async_reset("async_reset");

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) engine_color = 1'($urandom_range(0, 1));
      piece_reg = piece_tbl[$urandom_range(0, 13)];
      pos_reg = 6'($urandom_range(0, 63));
      enable = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < 8; i++) begin
        ray_in[i] = rand_ray();
        kn_in[i] = {($urandom_range(0, 3) != 0) ? engine_color : ~engine_color,
                    1'($urandom_range(0, 1)), 6'($urandom_range(0, 63))};
      end
      step($sformatf("rand%0d", n));
      if (n % 97 == 50) async_reset($sformatf("rand_reset%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
